pipe_if_id: RTL and testbench
=============================

Name: pipe_if_id

Overview:
- IF→ID pipeline stage. Sits between the pc/instruction-memory fetch path and instruction decode; feeds instr_reg and, downstream, pipe_id_ex.
- Registers the fetched instruction and its pc, with stall and flush support.
- Holds a 2-entry skid buffer that absorbs in-flight fetches during a stall.
- Detects halt leaving decode, stops fetch, and counts the pipeline drain before asserting halt_done.

Parameters:
BITS, 32, instruction/pc width
OPC_HI, 31, MSB of opcode field in instruction
OPC_LO, 26, LSB of opcode field
HALT_OPCODE, 6'b111111, opcode value identifying halt (width OPC_HI-OPC_LO+1)
DRAIN_CYCLES, 3, cycles after halt leaves ID before halt_done (covers S3, S4, S5)

Ports:
clk  input  1  system clock
rst_  input  1  reset, asynchronous, active-low
pc_s1  input  BITS  pc of fetched instruction
instr_s1  input  BITS  fetched instruction word
instr_valid_s1  input  1  instr_s1/pc_s1 valid this cycle
stall  input  1  hold ID stage (hazard unit)
flush  input  1  squash IF/ID contents (taken branch/jump)
pc_s2  output  BITS  pc of instruction in ID
pc_plus1_s2  output  BITS  pc_s2+1 (link address for jal)
instr_s2  output  BITS  instruction in ID; 0 when bubble
valid_s2  output  1  instr_s2 is real
fetch_en  output  1  load enable to pc
buf_count  output  2  skid buffer occupancy 0..2
halt_pending  output  1  state != RUN
halt_done  output  1  drain complete, sticky
ovf_err  output  1  sticky: valid fetch arrived with buffer full

Behaviour:
- Reset (async, rst_ low): pc_s2=0, instr_s2=0, valid_s2=0, buffer empty (buf_count=0), state=RUN, drain counter=0, halt_done=0, ovf_err=0. fetch_en=1 once state=RUN.
- pc_plus1_s2 = pc_s2 + 1, modulo 2^BITS. 0xFFFFFFFF wraps to 0.
- Skid buffer: 2-entry FIFO of {pc, instr}. It is written only from pc_s1/instr_s1.
- S2 load priority, per clock, in state RUN:
  - flush: buffer cleared; s2 becomes a bubble (valid_s2=0, instr_s2=0, pc_s2 held); incoming fetch discarded. flush overrides stall.
  - else stall: s2 holds. If instr_valid_s1, the fetch is pushed to the buffer. If the buffer is already full, the fetch is dropped and ovf_err=1.
  - else if buffer non-empty: s2 loads the buffer head (pop). If instr_valid_s1, the fetch is pushed in the same cycle, so count is unchanged.
  - else if instr_valid_s1: bypass; s2 loads pc_s1/instr_s1 directly. Latency 1 cycle.
  - else: s2 becomes a bubble.
- fetch_en = (state==RUN) & ~(buf_count==2) & ~(buf_count==1 & stall). This deasserts early enough to cover the one-cycle memory latency.
- Halt detection: when valid_s2 & instr_s2[OPC_HI:OPC_LO]==HALT_OPCODE & ~stall & ~flush (halt advances to ID/EX), the next state is DRAIN:
  - drain counter loads DRAIN_CYCLES-1;
  - buffer is cleared;
  - s2 becomes a bubble;
  - fetch_en=0.
- A halt squashed by flush in the same cycle does not enter DRAIN.
- DRAIN: s2 stays bubble; incoming fetches are discarded (no ovf_err); flush and stall are ignored. Counter decrements each cycle. At 0 the next state is DONE.
- DONE: halt_done=1, fetch_en=0, s2 bubble. Leaves DONE only on reset.
- halt_done rises exactly DRAIN_CYCLES+1 clocks after the edge at which the halt occupies s2 unstalled.
- Reset mid-DRAIN returns to RUN with all state cleared.

Test Plan:
- Reset then fetch stream pc 0,1,2 with instructions 0x11,0x22,0x33, no stall -> s2 shows each one cycle later; valid_s2=1; pc_plus1_s2=1,2,3; buf_count=0 throughout.
- Stall held 3 cycles while fetches pc 4,5 arrive -> s2 holds pc 3; buf_count goes 1,2; fetch_en=0 at count 2. Release stall -> s2 shows pc 4 then pc 5, in order, no loss; ovf_err=0.
- Stall and flush together with buf_count=2 and an incoming fetch -> next cycle valid_s2=0, instr_s2=0, buf_count=0, incoming fetch discarded.
- Force a fetch with buffer full and stall=1 (fetch_en ignored) -> ovf_err=1 and stays 1 until reset.
- Halt opcode 0xFC000000 reaches s2 unstalled at edge N -> fetch_en=0 and halt_pending=1 after N. halt_done=1 at edge N+4 with DRAIN_CYCLES=3. flush during DRAIN has no effect.
- Halt in s2 with flush asserted the same cycle -> state remains RUN, halt_pending=0. Also: pc_s1=0xFFFFFFFF reaching s2 -> pc_plus1_s2=0. rst_ low mid-DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pipe_if_id.sv
// ---------------------------------------------------------------------------
// pipe_if_id : IF -> ID pipeline stage
//
// Registers the fetched instruction and its pc for decode. Supports stall
// and flush from the hazard unit. A 2-entry skid buffer absorbs fetches that
// are already in flight when a stall arrives. A halt opcode leaving decode
// stops fetch, and the stage then counts the pipeline drain before raising
// a sticky halt_done.
//
// Ports:
//   clk, rst_        clock, asynchronous active-low reset
//   pc_s1, instr_s1  fetched pc / instruction word
//   instr_valid_s1   fetch data valid this cycle
//   stall, flush     hold / squash the ID stage
//   pc_s2, instr_s2  pc / instruction in ID (instr_s2 = 0 for a bubble)
//   pc_plus1_s2      pc_s2 + 1, the link address for jal
//   valid_s2         instr_s2 holds a real instruction
//   fetch_en         load enable for the pc register
//   buf_count        skid buffer occupancy, 0..2
//   halt_pending     a halt has left decode (draining or done)
//   halt_done        drain finished, sticky until reset
//   ovf_err          sticky: a valid fetch arrived while the buffer was full
// ---------------------------------------------------------------------------
module pipe_if_id #(
    parameter int BITS         = 32,
    parameter int OPC_HI       = 31,
    parameter int OPC_LO       = 26,
    parameter logic [OPC_HI-OPC_LO:0] HALT_OPCODE = 6'b111111,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [BITS-1:0] pc_s1,
    input  logic [BITS-1:0] instr_s1,
    input  logic            instr_valid_s1,
    input  logic            stall,
    input  logic            flush,
    output logic [BITS-1:0] pc_s2,
    output logic [BITS-1:0] pc_plus1_s2,
    output logic [BITS-1:0] instr_s2,
    output logic            valid_s2,
    output logic            fetch_en,
    output logic [1:0]      buf_count,
    output logic            halt_pending,
    output logic            halt_done,
    output logic            ovf_err
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic [BITS-1:0] buf_pc    [2];
    logic [BITS-1:0] buf_instr [2];
    logic            halt_in_s2;

    // Entry 0 of the skid buffer is always the head; pops shift entry 1 down.
    assign halt_in_s2   = valid_s2 && (instr_s2[OPC_HI:OPC_LO] == HALT_OPCODE);
    assign pc_plus1_s2  = pc_s2 + BITS'(1);
    assign halt_pending = (state != RUN);

    // Fetch is throttled one cycle early so the fetch already in flight from
    // the one-cycle memory still has a free buffer slot to land in.
    assign fetch_en = (state == RUN) && (buf_count != 2'd2)
                      && !((buf_count == 2'd1) && stall);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= RUN;
            drain_cnt    <= '0;
            pc_s2        <= '0;
            instr_s2     <= '0;
            valid_s2     <= 1'b0;
            buf_count    <= 2'd0;
            buf_pc[0]    <= '0;
            buf_pc[1]    <= '0;
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            halt_done    <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush) begin
                        // A flush also squashes a halt sitting in ID.
                        buf_count <= 2'd0;
                        valid_s2  <= 1'b0;
                        instr_s2  <= '0;
                    end else if (halt_in_s2 && !stall) begin
                        state     <= DRAIN;
                        drain_cnt <= CW'(DRAIN_CYCLES - 1);
                        buf_count <= 2'd0;
                        valid_s2  <= 1'b0;
                        instr_s2  <= '0;
                    end else if (stall) begin
                        if (instr_valid_s1) begin
                            if (buf_count == 2'd2) begin
                                ovf_err <= 1'b1;
                            end else begin
                                buf_pc[buf_count[0]]    <= pc_s1;
                                buf_instr[buf_count[0]] <= instr_s1;
                                buf_count               <= buf_count + 2'd1;
                            end
                        end
                    end else if (buf_count != 2'd0) begin
                        pc_s2        <= buf_pc[0];
                        instr_s2     <= buf_instr[0];
                        valid_s2     <= 1'b1;
                        buf_pc[0]    <= buf_pc[1];
                        buf_instr[0] <= buf_instr[1];
                        if (instr_valid_s1) begin
                            // Push lands behind whatever remains after the pop.
                            if (buf_count == 2'd1) begin
                                buf_pc[0]    <= pc_s1;
                                buf_instr[0] <= instr_s1;
                            end else begin
                                buf_pc[1]    <= pc_s1;
                                buf_instr[1] <= instr_s1;
                            end
                        end else begin
                            buf_count <= buf_count - 2'd1;
                        end
                    end else if (instr_valid_s1) begin
                        pc_s2    <= pc_s1;
                        instr_s2 <= instr_s1;
                        valid_s2 <= 1'b1;
                    end else begin
                        valid_s2 <= 1'b0;
                        instr_s2 <= '0;
                    end
                end
                DRAIN: begin
                    valid_s2 <= 1'b0;
                    instr_s2 <= '0;
                    if (drain_cnt == '0) begin
                        state     <= DONE;
                        halt_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                DONE: begin
                    valid_s2  <= 1'b0;
                    instr_s2  <= '0;
                    halt_done <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_if_id.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_id : bench for pipe_if_id
//
// Drives directed scenarios followed by randomized traffic. A behavioural
// model (queue-based skid buffer, countdown to halt_done) predicts every
// output after each clock edge.
// ---------------------------------------------------------------------------
module tb_pipe_if_id;

    localparam int DRAIN_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [31:0] pc_s1 = '0;
    logic [31:0] instr_s1 = '0;
    logic        instr_valid_s1 = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_s2;
    logic [31:0] pc_plus1_s2;
    logic [31:0] instr_s2;
    logic        valid_s2;
    logic        fetch_en;
    logic [1:0]  buf_count;
    logic        halt_pending;
    logic        halt_done;
    logic        ovf_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    logic [63:0] m_q[$];
    bit          m_draining;
    bit          m_done;
    int          m_drain_left;
    bit          m_ovf;

    pipe_if_id #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .pc_s1          (pc_s1),
        .instr_s1       (instr_s1),
        .instr_valid_s1 (instr_valid_s1),
        .stall          (stall),
        .flush          (flush),
        .pc_s2          (pc_s2),
        .pc_plus1_s2    (pc_plus1_s2),
        .instr_s2       (instr_s2),
        .valid_s2       (valid_s2),
        .fetch_en       (fetch_en),
        .buf_count      (buf_count),
        .halt_pending   (halt_pending),
        .halt_done      (halt_done),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pc = '0;
        m_instr = '0;
        m_valid = 1'b0;
        m_q.delete();
        m_draining = 1'b0;
        m_done = 1'b0;
        m_drain_left = 0;
        m_ovf = 1'b0;
    endtask

    // One clock of the stage as the rules describe it, using the inputs
    // held during the cycle that just ended.
    task automatic modelStep();
        bit run;
        run = !m_draining && !m_done;
        if (m_draining) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_draining = 1'b0;
                m_done = 1'b1;
            end
            m_valid = 1'b0;
            m_instr = '0;
        end else if (m_done) begin
            m_valid = 1'b0;
            m_instr = '0;
        end
        if (run) begin
            if (flush) begin
                m_q.delete();
                m_valid = 1'b0;
                m_instr = '0;
            end else if (m_valid && m_instr[31:26] == 6'h3F && !stall) begin
                m_draining = 1'b1;
                m_drain_left = DRAIN_CYCLES;
                m_q.delete();
                m_valid = 1'b0;
                m_instr = '0;
            end else if (stall) begin
                if (instr_valid_s1) begin
                    if (m_q.size() < 2) m_q.push_back({pc_s1, instr_s1});
                    else m_ovf = 1'b1;
                end
            end else if (m_q.size() > 0) begin
                {m_pc, m_instr} = m_q.pop_front();
                m_valid = 1'b1;
                if (instr_valid_s1) m_q.push_back({pc_s1, instr_s1});
            end else if (instr_valid_s1) begin
                m_pc = pc_s1;
                m_instr = instr_s1;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_instr = '0;
            end
        end
    endtask

    task automatic checkAll();
        bit run;
        run = !m_draining && !m_done;
        checkOutput("pc_s2", pc_s2, m_pc);
        checkOutput("pc_plus1_s2", pc_plus1_s2, 64'((m_pc + 32'd1) & 32'hFFFF_FFFF));
        checkOutput("instr_s2", instr_s2, m_instr);
        checkOutput("valid_s2", valid_s2, m_valid);
        checkOutput("buf_count", buf_count, m_q.size());
        checkOutput("fetch_en", fetch_en,
                    run && m_q.size() != 2 && !(m_q.size() == 1 && stall));
        checkOutput("halt_pending", halt_pending, !run);
        checkOutput("halt_done", halt_done, m_done);
        checkOutput("ovf_err", ovf_err, m_ovf);
    endtask

    task automatic applyStimulus(input bit s, input bit f, input bit v,
                                 input logic [31:0] pc, input logic [31:0] instr);
        stall = s;
        flush = f;
        instr_valid_s1 = v;
        pc_s1 = pc;
        instr_s1 = instr;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    // Asynchronous reset: outputs are checked before any clock edge.
    task automatic resetDut();
        stall = 1'b0;
        flush = 1'b0;
        instr_valid_s1 = 1'b0;
        rst_ = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        rst_ = 1'b1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        r = $urandom;
        if (r[31:26] == 6'h3F) r[31] = 1'b0;
        if ($urandom_range(0, 59) == 0) r[31:26] = 6'h3F;
        return r;
    endfunction

    initial begin
        logic [31:0] next_pc;

        // Plain stream, then stall with two fetches in flight and release
        resetDut();
        applyStimulus(0, 0, 1, 32'd0, 32'h11);
        applyStimulus(0, 0, 1, 32'd1, 32'h22);
        applyStimulus(0, 0, 1, 32'd2, 32'h33);
        applyStimulus(0, 0, 1, 32'd3, 32'h44);
        applyStimulus(1, 0, 1, 32'd4, 32'h55);
        applyStimulus(1, 0, 1, 32'd5, 32'h66);
        checkOutput("fetch_en_at_full", fetch_en, 0);
        applyStimulus(1, 0, 0, 32'd6, 32'h77);
        applyStimulus(0, 0, 0, 32'd6, 32'h77);
        checkOutput("drain_order_pc4", pc_s2, 32'd4);
        applyStimulus(0, 0, 0, 32'd6, 32'h77);
        checkOutput("drain_order_pc5", pc_s2, 32'd5);
        applyStimulus(0, 0, 0, 32'd6, 32'h77);

        // Stall + flush with a full buffer and an incoming fetch
        applyStimulus(1, 0, 1, 32'd7, 32'h88);
        applyStimulus(1, 0, 1, 32'd8, 32'h99);
        applyStimulus(1, 1, 1, 32'd9, 32'hAA);
        checkOutput("flush_bubble", valid_s2, 0);

        // Overflow: fetch into a full buffer while stalled, then sticky
        applyStimulus(1, 0, 1, 32'd10, 32'h1);
        applyStimulus(1, 0, 1, 32'd11, 32'h2);
        applyStimulus(1, 0, 1, 32'd12, 32'h3);
        checkOutput("ovf_set", ovf_err, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 32'd0, 32'd0);
        checkOutput("ovf_sticky", ovf_err, 1);

        // Halt with flush during the drain; halt_done at N+4
        resetDut();
        applyStimulus(0, 0, 1, 32'd20, 32'hFC00_0000);
        applyStimulus(0, 0, 1, 32'd21, 32'h1234);
        checkOutput("halt_stops_fetch", fetch_en, 0);
        applyStimulus(0, 1, 1, 32'd22, 32'h5678);
        applyStimulus(1, 1, 1, 32'd23, 32'h9ABC);
        checkOutput("halt_done_early", halt_done, 0);
        applyStimulus(0, 1, 0, 32'd24, 32'd0);
        checkOutput("halt_done_n4", halt_done, 1);
        applyStimulus(0, 0, 1, 32'd25, 32'h1);

        // Halt squashed by flush; pc wrap for the link address
        resetDut();
        applyStimulus(0, 0, 1, 32'd30, 32'hFC00_0000);
        applyStimulus(0, 1, 1, 32'd31, 32'h1);
        checkOutput("squashed_halt", halt_pending, 0);
        applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 32'h2);
        checkOutput("pc_wrap", pc_plus1_s2, 32'd0);

        // Reset asserted mid-drain
        applyStimulus(0, 0, 1, 32'd40, 32'hFC00_0000);
        applyStimulus(0, 0, 0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0, 32'd0);
        resetDut();

        // Randomized traffic in several reset-separated phases
        next_pc = 32'd100;
        for (int ph = 0; ph < 8; ph++) begin
            resetDut();
            for (int c = 0; c < 150; c++) begin
                bit s, f, v;
                s = ($urandom_range(0, 2) == 0);
                f = ($urandom_range(0, 9) == 0);
                v = ($urandom_range(0, 3) != 0);
                if (ph == 7 && c == 75) begin
                    applyStimulus(s, f, v, next_pc, randInstr());
                    rst_ = 1'b0;
                    #1;
                    modelReset();
                    checkAll();
                    rst_ = 1'b1;
                end else begin
                    applyStimulus(s, f, v, next_pc, randInstr());
                end
                if (v) next_pc = next_pc + 32'd1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
